// File: rtl/cnna_mul_pipe_if.sv
// Valid/ready stream bundle for cnna_mul_pipe: operand pair in, result plus overflow flag out.
// master = the surrounding datapath, slave = the multiplier pipe.
interface cnna_mul_pipe_if #(
    parameter int DIN0_WIDTH = 5,
    parameter int DIN1_WIDTH = 15,
    parameter int DOUT_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  ovf;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, dout, ovf
    );
endinterface

// File: rtl/cnna_mul_pipe.sv
// Parametrised pipelined multiplier with rounding shift, saturate/wrap and overflow flag.
// Elastic pipe: every stage has its own valid bit, so bubbles collapse under back-pressure.
module cnna_mul_pipe #(
    parameter int DIN0_WIDTH = 5,
    parameter int DIN1_WIDTH = 15,
    parameter int DOUT_WIDTH = 16,
    parameter int NUM_STAGE  = 3,
    parameter int SIGNED0    = 0,
    parameter int SIGNED1    = 0,
    parameter int SHIFT      = 0,
    parameter int SAT        = 0
) (
    input  logic           ap_clk,
    input  logic           ap_rst_n,
    cnna_mul_pipe_if.slave bus
);
    // One spare bit over the full product so the rounding add can never wrap.
    localparam int  P          = DIN0_WIDTH + DIN1_WIDTH + 1;
    localparam int  Q          = P + 1;
    localparam bit  OUT_SIGNED = (SIGNED0 != 0) || (SIGNED1 != 0);
    localparam int  RND_POS    = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [Q-1:0] RND   = (SHIFT > 0) ? Q'(1) << RND_POS : Q'(0);
    localparam logic signed [Q-1:0] MAX_V = OUT_SIGNED ? (Q'(1) << (DOUT_WIDTH - 1)) - Q'(1)
                                                       : (Q'(1) << DOUT_WIDTH) - Q'(1);
    localparam logic signed [Q-1:0] MIN_V = OUT_SIGNED ? -(Q'(1) << (DOUT_WIDTH - 1)) : Q'(0);

    typedef struct packed {
        logic                  ovf;
        logic [DOUT_WIDTH-1:0] dout;
    } res_t;

    logic signed [Q-1:0]  op0, op1, prod, shifted;
    res_t                 res_in;
    res_t                 last_in;
    logic                 last_v_in;
    res_t                 out_q;
    logic [NUM_STAGE-1:0] v_q;
    logic [NUM_STAGE-1:0] adv;

    // Arithmetic is done in front of S1; synthesis register balancing may retime it into the pipe.
    assign op0     = (SIGNED0 != 0) ? Q'($signed(bus.din0)) : Q'($unsigned(bus.din0));
    assign op1     = (SIGNED1 != 0) ? Q'($signed(bus.din1)) : Q'($unsigned(bus.din1));
    assign prod    = op0 * op1;
    assign shifted = (prod + RND) >>> SHIFT;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        res_in.ovf  = 1'b0;
        res_in.dout = shifted[DOUT_WIDTH-1:0];
        if (shifted > MAX_V) begin
            res_in.ovf = 1'b1;
            if (SAT != 0) res_in.dout = MAX_V[DOUT_WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            res_in.ovf = 1'b1;
            if (SAT != 0) res_in.dout = MIN_V[DOUT_WIDTH-1:0];
        end
    end

    // A stage may load when it is empty or its content moves on this cycle.
    always_comb begin
        logic chain;
        adv   = '0;
        chain = bus.out_ready;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            chain  = !v_q[k] || chain;
            adv[k] = chain;
        end
    end

    assign bus.in_ready = adv[0];

    generate
        if (NUM_STAGE > 1) begin : g_mid
            res_t mid_q [NUM_STAGE-1];

            // NOTE: intermediate data registers carry no reset; the valid bits alone qualify them.
            always_ff @(posedge ap_clk) begin
                if (adv[0]) mid_q[0] <= res_in;
                for (int k = 1; k < NUM_STAGE - 1; k++) begin
                    if (adv[k]) mid_q[k] <= mid_q[k-1];
                end
            end

            assign last_in   = mid_q[NUM_STAGE-2];
            assign last_v_in = v_q[NUM_STAGE-2];
        end else begin : g_direct
            assign last_in   = res_in;
            assign last_v_in = bus.in_valid;
        end
    endgenerate

    // The output register only loads real items, so dout/ovf keep their last value while idle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            v_q   <= '0;
            out_q <= '0;
        end else begin
            if (adv[0]) v_q[0] <= bus.in_valid;
            for (int k = 1; k < NUM_STAGE; k++) begin
                if (adv[k]) v_q[k] <= v_q[k-1];
            end
            if (adv[NUM_STAGE-1] && last_v_in) out_q <= last_in;
        end
    end

    assign bus.out_valid = v_q[NUM_STAGE-1];
    assign bus.dout      = out_q.dout;
    assign bus.ovf       = out_q.ovf;
endmodule

// File: tb/tb_cnna_mul_pipe.sv
// Bench for cnna_mul_pipe: six parameter sets share one clock/reset and are driven by directed vectors,
// a back-pressure stream with a scoreboard, and mid-stream resets.
module tb_cnna_mul_pipe;
    localparam int NDUT = 6;
    localparam int NS_P  [NDUT] = '{3, 3, 3, 3, 1, 8};
    localparam int SG_P  [NDUT] = '{0, 0, 1, 0, 0, 0};
    localparam int SAT_P [NDUT] = '{0, 1, 1, 0, 0, 0};
    localparam int SH_P  [NDUT] = '{0, 0, 0, 4, 0, 0};

    typedef struct {
        int          dut;
        logic [4:0]  a;
        logic [14:0] b;
        logic [15:0] exp_dout;
        logic        exp_ovf;
    } vec_t;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n = 1'b0;
    logic [NDUT-1:0] in_valid = '0;
    logic [NDUT-1:0] out_ready = '1;
    logic [4:0]      din0 = '0;
    logic [14:0]     din1 = '0;
    logic [NDUT-1:0] in_ready, out_valid, ovf;
    logic [15:0]     dout [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    always #5 ap_clk = ~ap_clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        cnna_mul_pipe_if #(.DIN0_WIDTH(5), .DIN1_WIDTH(15), .DOUT_WIDTH(16)) u_if ();

        assign u_if.in_valid  = in_valid[g];
        assign u_if.din0      = din0;
        assign u_if.din1      = din1;
        assign u_if.out_ready = out_ready[g];
        assign in_ready[g]    = u_if.in_ready;
        assign out_valid[g]   = u_if.out_valid;
        assign dout[g]        = u_if.dout;
        assign ovf[g]         = u_if.ovf;

        cnna_mul_pipe #(
            .DIN0_WIDTH(5), .DIN1_WIDTH(15), .DOUT_WIDTH(16),
            .NUM_STAGE(NS_P[g]), .SIGNED0(SG_P[g]), .SIGNED1(SG_P[g]),
            .SHIFT(SH_P[g]), .SAT(SAT_P[g])
        ) u_dut (
            .ap_clk  (ap_clk),
            .ap_rst_n(ap_rst_n),
            .bus     (u_if.slave)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One item into one DUT; the result must appear exactly NUM_STAGE cycles after in_valid is presented.
    task automatic run_vec(input int idx, input vec_t v);
        int lat = NS_P[v.dut];
        @(negedge ap_clk);
        din0 = v.a;
        din1 = v.b;
        in_valid[v.dut] = 1'b1;
        #1;
        check($sformatf("v%0d_in_ready", idx), 32'(in_ready[v.dut]), 32'd1);
        @(posedge ap_clk);
        #1;
        in_valid[v.dut] = 1'b0;
        for (int c = 1; c < lat; c++) begin
            check($sformatf("v%0d_early_valid_c%0d", idx, c), 32'(out_valid[v.dut]), 32'd0);
            @(posedge ap_clk);
            #1;
        end
        check($sformatf("v%0d_out_valid", idx), 32'(out_valid[v.dut]), 32'd1);
        check($sformatf("v%0d_dout", idx), 32'(dout[v.dut]), 32'(v.exp_dout));
        check($sformatf("v%0d_ovf", idx), 32'(ovf[v.dut]), 32'(v.exp_ovf));
    endtask

    // Ten items into the 3-stage DUT with a bubble at cycle 3 and a stall on cycles 5..9.
    task automatic stream_test();
        int   q[$];
        int   sent = 0;
        int   got = 0;
        logic acc, drn;
        for (int c = 0; c < 60 && got < 10; c++) begin
            @(negedge ap_clk);
            out_ready[0] = !(c >= 5 && c <= 9);
            in_valid[0]  = (sent < 10) && (c != 3);
            din0 = 5'(sent);
            din1 = 15'(sent + 1);
            #1;
            check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready[0]), 32'(out_ready[0] || q.size() < 3));
            if (out_valid[0]) begin
                if (q.size() == 0) begin
                    check($sformatf("bp_spurious_c%0d", c), 32'(out_valid[0]), 32'd0);
                end else begin
                    check($sformatf("bp_dout_c%0d", c), 32'(dout[0]), 32'(q[0]));
                    check($sformatf("bp_ovf_c%0d", c), 32'(ovf[0]), 32'd0);
                end
            end
            acc = in_valid[0] && in_ready[0];
            drn = out_valid[0] && out_ready[0];
            @(posedge ap_clk);
            if (drn && q.size() > 0) begin
                q.delete(0);
                got++;
            end
            if (acc) begin
                q.push_back(sent * (sent + 1));
                sent++;
            end
        end
        check("bp_drained_count", 32'(got), 32'd10);
        check("bp_accepted_count", 32'(sent), 32'd10);
        @(negedge ap_clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
    endtask

    // Load three items, then reset asynchronously between clock edges.
    task automatic reset_test(input int k);
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            in_valid[k] = 1'b1;
            din0 = 5'd3;
            din1 = 15'(5 + i);
            @(posedge ap_clk);
        end
        @(negedge ap_clk);
        in_valid[k] = 1'b0;
        #2;
        ap_rst_n = 1'b0;
        #1;
        check($sformatf("rst%0d_out_valid", k), 32'(out_valid[k]), 32'd0);
        check($sformatf("rst%0d_dout", k), 32'(dout[k]), 32'd0);
        check($sformatf("rst%0d_ovf", k), 32'(ovf[k]), 32'd0);
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        check($sformatf("rst%0d_in_ready", k), 32'(in_ready[k]), 32'd1);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("rst%0d_stale_c%0d", k, c), 32'(out_valid[k]), 32'd0);
            @(posedge ap_clk);
            #1;
        end
    endtask

    initial begin
        vec_t vecs[$];
        vecs.push_back('{0, 5'd31,   15'd32767,  16'h7FE1, 1'b1});
        vecs.push_back('{0, 5'd3,    15'd5,      16'd15,   1'b0});
        vecs.push_back('{0, 5'd2,    15'd32767,  16'hFFFE, 1'b0});
        vecs.push_back('{0, 5'd3,    15'd32767,  16'h7FFD, 1'b1});
        vecs.push_back('{1, 5'd31,   15'd32767,  16'hFFFF, 1'b1});
        vecs.push_back('{1, 5'd2,    15'd100,    16'd200,  1'b0});
        vecs.push_back('{1, 5'd4,    15'd16384,  16'hFFFF, 1'b1});
        vecs.push_back('{1, 5'd2,    15'd32767,  16'hFFFE, 1'b0});
        vecs.push_back('{2, 5'h10,   15'd16383,  16'h8000, 1'b1});
        vecs.push_back('{2, 5'h1D,   15'h7FF9,   16'd21,   1'b0});
        vecs.push_back('{2, 5'h10,   15'h7800,   16'h7FFF, 1'b1});
        vecs.push_back('{2, 5'h10,   15'h0800,   16'h8000, 1'b0});
        vecs.push_back('{3, 5'd3,    15'd11,     16'd2,    1'b0});
        vecs.push_back('{3, 5'd3,    15'd7,      16'd1,    1'b0});
        vecs.push_back('{3, 5'd1,    15'd7,      16'd0,    1'b0});
        vecs.push_back('{3, 5'd1,    15'd8,      16'd1,    1'b0});
        vecs.push_back('{3, 5'd31,   15'd32767,  16'hF7FE, 1'b0});
        vecs.push_back('{4, 5'd3,    15'd5,      16'd15,   1'b0});
        vecs.push_back('{4, 5'd31,   15'd32767,  16'h7FE1, 1'b1});
        vecs.push_back('{5, 5'd31,   15'd32767,  16'h7FE1, 1'b1});
        vecs.push_back('{5, 5'd2,    15'd100,    16'd200,  1'b0});

        repeat (3) @(posedge ap_clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("init%0d_out_valid", k), 32'(out_valid[k]), 32'd0);
            check($sformatf("init%0d_dout", k), 32'(dout[k]), 32'd0);
            check($sformatf("init%0d_ovf", k), 32'(ovf[k]), 32'd0);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("init%0d_in_ready", k), 32'(in_ready[k]), 32'd1);
        end

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        stream_test();

        reset_test(0);
        reset_test(4);
        reset_test(5);

        run_vec(100, '{4, 5'd7, 15'd9,  16'd63, 1'b0});
        run_vec(101, '{5, 5'd7, 15'd9,  16'd63, 1'b0});
        run_vec(102, '{0, 5'd7, 15'd9,  16'd63, 1'b0});

        repeat (2) @(posedge ap_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule
